sync_event_filter: RTL and testbench



---
 rtl/sync_event_filter.sv | 157 +++++++++++++++
 tb/tb_sync_event_filter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_event_filter.sv
// sync_event_filter: glitch filter for an already-synchronized level in the clk2 domain.
// The output level changes only after FILT_LEN consecutive samples of the new level.
// Produces one-cycle rise/fall strobes and a saturating count of qualified rising edges.
// Optional build macro GLITCH_CNT_EN adds a saturating count of rejected transitions.
module sync_event_filter #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned GCNT_W   = 8
) (
  input  logic              clk2,
  input  logic              rst2,
  input  logic              sync_in,
  input  logic              clr,
  output logic              filt_out,
  output logic              rise,
  output logic              fall,
  output logic [CNT_W-1:0]  edge_cnt,
`ifdef GLITCH_CNT_EN
  output logic [GCNT_W-1:0] glitch_cnt,
`endif
  output logic              cnt_sat
);

  // Qualification counter only has to hold 0..FILT_LEN.
  localparam int unsigned QW = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {S_LOW, S_QH, S_HIGH, S_QL} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           r_state, w_state_d;
  logic [QW-1:0]    r_qcnt, w_qcnt_d, w_qcnt_inc;
  logic             r_filt, w_filt_d;
  logic             r_rise, w_rise_d;
  logic             r_fall, w_fall_d;
  logic             w_glitch;
  logic             w_qual_done;
  logic [CNT_W-1:0] r_edge_cnt, w_edge_inc;
  logic             r_cnt_sat;

  // In the stable states qcnt is 0, so the same "next sample completes" test also covers
  // FILT_LEN == 1, where the first differing sample commits immediately.
  assign w_qcnt_inc  = r_qcnt + QW'(1);
  assign w_qual_done = (w_qcnt_inc == QW'(FILT_LEN));
  assign w_edge_inc  = r_edge_cnt + CNT_W'(1);

  // Next-state and strobe decode for the stability filter.
  always_comb begin
    w_state_d = r_state;
    w_qcnt_d  = r_qcnt;
    w_filt_d  = r_filt;
    w_rise_d  = 1'b0;
    w_fall_d  = 1'b0;
    w_glitch  = 1'b0;
    unique case (r_state)
      S_LOW, S_QH: begin
        if (sync_in) begin
          if (w_qual_done) begin
            w_state_d = S_HIGH;
            w_qcnt_d  = '0;
            w_filt_d  = 1'b1;
            w_rise_d  = 1'b1;
          end else begin
            w_state_d = S_QH;
            w_qcnt_d  = w_qcnt_inc;
          end
        end else if (r_state == S_QH) begin
          w_state_d = S_LOW;
          w_qcnt_d  = '0;
          w_glitch  = 1'b1;
        end
      end
      S_HIGH, S_QL: begin
        if (!sync_in) begin
          if (w_qual_done) begin
            w_state_d = S_LOW;
            w_qcnt_d  = '0;
            w_filt_d  = 1'b0;
            w_fall_d  = 1'b1;
          end else begin
            w_state_d = S_QL;
            w_qcnt_d  = w_qcnt_inc;
          end
        end else if (r_state == S_QL) begin
          w_state_d = S_HIGH;
          w_qcnt_d  = '0;
          w_glitch  = 1'b1;
        end
      end
      default: begin
        w_state_d = S_LOW;
        w_qcnt_d  = '0;
      end
    endcase
  end

  // Filter state, filtered level and strobes; reset discards any partial qualification.
  always_ff @(posedge clk2) begin
    if (rst2) begin
      r_state <= S_LOW;
      r_qcnt  <= '0;
      r_filt  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_qcnt  <= w_qcnt_d;
      r_filt  <= w_filt_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
    end
  end

  // Saturating qualified-edge counter with sticky saturation flag; clr beats a coincident rise.
  always_ff @(posedge clk2) begin
    if (rst2) begin
      r_edge_cnt <= '0;
      r_cnt_sat  <= 1'b0;
    end else if (clr) begin
      r_edge_cnt <= '0;
      r_cnt_sat  <= 1'b0;
    end else if (w_rise_d && (r_edge_cnt != CntMax)) begin
      r_edge_cnt <= w_edge_inc;
      if (w_edge_inc == CntMax) begin
        r_cnt_sat <= 1'b1;
      end
    end
  end

`ifdef GLITCH_CNT_EN
  localparam logic [GCNT_W-1:0] GcntMax = '1;

  logic [GCNT_W-1:0] r_glitch_cnt;

  // Saturating count of rejected transitions; clr beats a coincident glitch.
  always_ff @(posedge clk2) begin
    if (rst2 || clr) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != GcntMax)) begin
      r_glitch_cnt <= r_glitch_cnt + GCNT_W'(1);
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  // Glitch events and the counter width only matter when the glitch counter is built.
  logic w_unused_glitch;
  assign w_unused_glitch = w_glitch ^ GCNT_W[0];
`endif

  assign filt_out = r_filt;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign edge_cnt = r_edge_cnt;
  assign cnt_sat  = r_cnt_sat;

endmodule

// File: tb/tb_sync_event_filter.sv
// Bench for sync_event_filter: three instances (FILT_LEN=4, FILT_LEN=4/CNT_W=3, FILT_LEN=1)
// share one stimulus stream; directed scenarios plus a randomized run against a run-length model.
module tb_sync_event_filter;

  logic       clk2 = 1'b0;
  logic       rst2;
  logic       sync_in;
  logic       clr;
  logic [2:0] filt_o, rise_o, fall_o, sat_o;
  logic [7:0] ec_f4, ec_f1;
  logic [2:0] ec_sat;
`ifdef GLITCH_CNT_EN
  logic [7:0] gc_f4, gc_sat, gc_f1;
`endif

  always #5 clk2 = ~clk2;

  sync_event_filter #(.FILT_LEN(4), .CNT_W(8), .GCNT_W(8)) u_f4 (
    .clk2(clk2), .rst2(rst2), .sync_in(sync_in), .clr(clr),
    .filt_out(filt_o[0]), .rise(rise_o[0]), .fall(fall_o[0]), .edge_cnt(ec_f4),
`ifdef GLITCH_CNT_EN
    .glitch_cnt(gc_f4),
`endif
    .cnt_sat(sat_o[0])
  );

  sync_event_filter #(.FILT_LEN(4), .CNT_W(3), .GCNT_W(8)) u_sat (
    .clk2(clk2), .rst2(rst2), .sync_in(sync_in), .clr(clr),
    .filt_out(filt_o[1]), .rise(rise_o[1]), .fall(fall_o[1]), .edge_cnt(ec_sat),
`ifdef GLITCH_CNT_EN
    .glitch_cnt(gc_sat),
`endif
    .cnt_sat(sat_o[1])
  );

  sync_event_filter #(.FILT_LEN(1), .CNT_W(8), .GCNT_W(8)) u_f1 (
    .clk2(clk2), .rst2(rst2), .sync_in(sync_in), .clr(clr),
    .filt_out(filt_o[2]), .rise(rise_o[2]), .fall(fall_o[2]), .edge_cnt(ec_f1),
`ifdef GLITCH_CNT_EN
    .glitch_cnt(gc_f1),
`endif
    .cnt_sat(sat_o[2])
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the filtered level flips once the trailing run of identical samples
  // (counted since reset) reaches FILT_LEN and differs from the current level.
  int m_len  [3] = '{4, 4, 1};
  int m_cmax [3] = '{255, 7, 255};
  int m_gmax = 255;
  bit m_filt [3];
  bit m_rise [3];
  bit m_fall [3];
  bit m_sat  [3];
  int m_ecnt [3];
  int m_gcnt [3];
  int run  = 0;
  bit prev = 1'b0;
  bit hist = 1'b0;

  // Drive one cycle of inputs, advance the model at the edge, settle after the edge.
  task automatic step(input bit s, input bit r, input bit c);
    bit glitch;
    sync_in = s;
    rst2    = r;
    clr     = c;
    @(posedge clk2);
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_filt[i] = 1'b0; m_rise[i] = 1'b0; m_fall[i] = 1'b0;
        m_sat[i]  = 1'b0; m_ecnt[i] = 0;    m_gcnt[i] = 0;
      end
      run  = 0;
      hist = 1'b0;
    end else begin
      run = (hist && s == prev) ? run + 1 : 1;
      for (int i = 0; i < 3; i++) begin
        glitch    = 1'b0;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (s != m_filt[i] && run == m_len[i]) begin
          m_filt[i] = s;
          m_rise[i] = s;
          m_fall[i] = !s;
        end else if (s == m_filt[i] && hist && prev != m_filt[i]) begin
          glitch = 1'b1;
        end
        if (c) begin
          m_ecnt[i] = 0;
          m_sat[i]  = 1'b0;
          m_gcnt[i] = 0;
        end else begin
          if (m_rise[i] && m_ecnt[i] < m_cmax[i]) m_ecnt[i] = m_ecnt[i] + 1;
          if (m_ecnt[i] == m_cmax[i]) m_sat[i] = 1'b1;
          if (glitch && m_gcnt[i] < m_gmax) m_gcnt[i] = m_gcnt[i] + 1;
        end
      end
      prev = s;
      hist = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_total++;
    if (filt_o[0] !== 1'b0) begin
      n_bad++; $display("FAIL reset_filt got=%b exp=0", filt_o[0]);
    end
    n_total++;
    if (rise_o[0] !== 1'b0) begin
      n_bad++; $display("FAIL reset_rise got=%b exp=0", rise_o[0]);
    end
    n_total++;
    if (ec_f4 !== 8'd0) begin
      n_bad++; $display("FAIL reset_edge_cnt got=%0d exp=0", ec_f4);
    end
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      n_total++;
      if (rise_o[0] !== (k == 4)) begin
        n_bad++; $display("FAIL reset_release_rise k=%0d got=%b exp=%b", k, rise_o[0], k == 4);
      end
      n_total++;
      if (rise_o[2] !== (k == 1)) begin
        n_bad++; $display("FAIL reset_release_rise_f1 k=%0d got=%b exp=%b", k, rise_o[2], k == 1);
      end
    end
    n_total++;
    if (ec_f4 !== 8'd1) begin
      n_bad++; $display("FAIL reset_release_edge_cnt got=%0d exp=1", ec_f4);
    end
  endtask

  task automatic test_clean_pulse();
    bit s;
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 18; k++) begin
      s = (k < 10);
      step(s, 1'b0, 1'b0);
      n_total++;
      if (rise_o[0] !== (k == 3) || fall_o[0] !== (k == 13)) begin
        n_bad++;
        $display("FAIL pulse_strobes k=%0d got rise=%b fall=%b exp rise=%b fall=%b",
                 k, rise_o[0], fall_o[0], k == 3, k == 13);
      end
      n_total++;
      if (filt_o[0] !== (k >= 3 && k < 13)) begin
        n_bad++; $display("FAIL pulse_filt k=%0d got=%b exp=%b", k, filt_o[0], k >= 3 && k < 13);
      end
    end
    n_total++;
    if (ec_f4 !== 8'd1) begin
      n_bad++; $display("FAIL pulse_edge_cnt got=%0d exp=1", ec_f4);
    end
  endtask

  task automatic test_glitch();
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(k < 3, 1'b0, 1'b0);
      n_total++;
      if (filt_o[0] !== 1'b0 || rise_o[0] !== 1'b0 || fall_o[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL glitch_quiet k=%0d got filt=%b rise=%b fall=%b exp all 0",
                 k, filt_o[0], rise_o[0], fall_o[0]);
      end
    end
    n_total++;
    if (ec_f4 !== 8'd0) begin
      n_bad++; $display("FAIL glitch_edge_cnt got=%0d exp=0", ec_f4);
    end
`ifdef GLITCH_CNT_EN
    n_total++;
    if (gc_f4 !== 8'd1) begin
      n_bad++; $display("FAIL glitch_cnt got=%0d exp=1", gc_f4);
    end
`endif
  endtask

  task automatic test_saturation();
    int exp_cnt;
    step(1'b0, 1'b1, 1'b0);
    for (int p = 1; p <= 9; p++) begin
      repeat (4) step(1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      exp_cnt = (p < 7) ? p : 7;
      n_total++;
      if (int'(ec_sat) != exp_cnt) begin
        n_bad++; $display("FAIL sat_edge_cnt p=%0d got=%0d exp=%0d", p, ec_sat, exp_cnt);
      end
      n_total++;
      if (sat_o[1] !== (p >= 7)) begin
        n_bad++; $display("FAIL sat_flag p=%0d got=%b exp=%b", p, sat_o[1], p >= 7);
      end
    end
    repeat (4) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    n_total++;
    if (ec_sat !== 3'd0 || sat_o[1] !== 1'b0 || filt_o[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_clr got cnt=%0d sat=%b filt=%b exp cnt=0 sat=0 filt=1",
               ec_sat, sat_o[1], filt_o[1]);
    end
  endtask

  task automatic test_simultaneous();
    bit s;
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    n_total++;
    if (rise_o[0] !== 1'b1 || ec_f4 !== 8'd0) begin
      n_bad++; $display("FAIL clr_commit got rise=%b cnt=%0d exp rise=1 cnt=0", rise_o[0], ec_f4);
    end
    step(1'b1, 1'b0, 1'b0);
    n_total++;
    if (rise_o[0] !== 1'b0 || ec_f4 !== 8'd0) begin
      n_bad++; $display("FAIL clr_commit_after got rise=%b cnt=%0d exp rise=0 cnt=0", rise_o[0], ec_f4);
    end
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      s = (k % 2 == 0);
      step(s, 1'b0, 1'b0);
      n_total++;
      if (filt_o[2] !== s || rise_o[2] !== s || fall_o[2] !== !s) begin
        n_bad++;
        $display("FAIL len1_follow k=%0d got filt=%b rise=%b fall=%b exp filt=%b rise=%b fall=%b",
                 k, filt_o[2], rise_o[2], fall_o[2], s, s, !s);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      n_total++;
      if (rise_o[0] !== (k == 4)) begin
        n_bad++; $display("FAIL reset_mid_rise k=%0d got=%b exp=%b", k, rise_o[0], k == 4);
      end
    end
  endtask

  task automatic test_random();
    bit s;
    bit r;
    bit c;
    int hold;
    int act_ec;
    int act_gc;
    hold = 0;
    s    = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        s    = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 6);
      end
      hold--;
      c = ($urandom_range(0, 31) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(s, r, c);
      for (int i = 0; i < 3; i++) begin
        act_ec = (i == 0) ? int'(ec_f4) : (i == 1) ? int'(ec_sat) : int'(ec_f1);
        n_total++;
        if (filt_o[i] !== m_filt[i] || rise_o[i] !== m_rise[i] || fall_o[i] !== m_fall[i]) begin
          n_bad++;
          $display("FAIL rand_level n=%0d dut=%0d got filt=%b rise=%b fall=%b exp filt=%b rise=%b fall=%b",
                   n, i, filt_o[i], rise_o[i], fall_o[i], m_filt[i], m_rise[i], m_fall[i]);
        end
        n_total++;
        if (act_ec != m_ecnt[i] || sat_o[i] !== m_sat[i]) begin
          n_bad++;
          $display("FAIL rand_count n=%0d dut=%0d got cnt=%0d sat=%b exp cnt=%0d sat=%b",
                   n, i, act_ec, sat_o[i], m_ecnt[i], m_sat[i]);
        end
`ifdef GLITCH_CNT_EN
        act_gc = (i == 0) ? int'(gc_f4) : (i == 1) ? int'(gc_sat) : int'(gc_f1);
`else
        act_gc = m_gcnt[i];
`endif
        n_total++;
        if (act_gc != m_gcnt[i]) begin
          n_bad++;
          $display("FAIL rand_glitch n=%0d dut=%0d got=%0d exp=%0d", n, i, act_gc, m_gcnt[i]);
        end
      end
    end
  endtask

  initial begin
    rst2    = 1'b1;
    sync_in = 1'b0;
    clr     = 1'b0;
    test_reset();
    test_clean_pulse();
    test_glitch();
    test_saturation();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
